// File: rtl/shift_pipe.sv
//==============================================================================
// Module      : shift_pipe
// Description : Pipelined barrel shifter with valid/ready flow control.
//               Stage k applies a 2^k shift (SLL, SRL, SRA or ROL) when its
//               carried shift-amount bit is set; OP, the remaining shift bits
//               and a valid flag travel with the data. A single global stall
//               freezes every stage while a result waits for the consumer.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module shift_pipe #(
  parameter int WIDTH = 32
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       IN_VALID,
  output logic                       IN_READY,
  input  logic [1:0]                 OP,
  input  logic [WIDTH-1:0]           D,
  input  logic [$clog2(WIDTH)-1:0]   S,
  output logic                       OUT_VALID,
  input  logic                       OUT_READY,
  output logic [WIDTH-1:0]           Y,
  output logic                       ZERO,
  output logic                       BUSY
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [1:0] C_OP_SLL = 2'b00;
  localparam logic [1:0] C_OP_SRL = 2'b01;
  localparam logic [1:0] C_OP_SRA = 2'b10;

  // One stage of the barrel: shift by amt when en is set, else pass through.
  // SRA fills from the MSB of this stage's input, which composes correctly
  // across stages because earlier stages already replicated the sign.
  function automatic logic [WIDTH-1:0] stage_shift(
    input logic [WIDTH-1:0] x,
    input logic [1:0]       op,
    input logic             en,
    input int unsigned      amt
  );
    logic [WIDTH-1:0] r;
    r = x;
    if (en) begin
      case (op)
        C_OP_SLL: r = x << amt;
        C_OP_SRL: r = x >> amt;
        C_OP_SRA: r = $signed(x) >>> amt;
        default:  r = (x << amt) | (x >> (WIDTH - amt));
      endcase
    end
    return r;
  endfunction

  logic                   stall;
  logic [SW-1:0][WIDTH-1:0] stage_data;
  logic [SW-1:0]          stage_valid;
  logic                   zero_d;
  logic                   zero_q;

  // The whole pipe freezes only when a finished result is not being taken.
  assign stall     = stage_valid[SW-1] & ~OUT_READY;
  assign IN_READY  = ~stall;
  assign OUT_VALID = stage_valid[SW-1];
  assign Y         = stage_data[SW-1];
  assign ZERO      = zero_q & stage_valid[SW-1];
  assign BUSY      = |stage_valid;

  for (genvar k = 0; k < SW; k++) begin : g_stage
    localparam int unsigned AMT = 1 << k;

    logic [WIDTH-1:0] src_data;
    logic [1:0]       src_op;
    logic [SW-k-1:0]  src_s;   // bit 0 controls this stage, upper bits ride on
    logic             src_valid;
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;
    logic             valid_d;
    logic             valid_q;

    if (k == 0) begin : g_src_in
      // Bubbles enter with a zeroed payload so idle inputs never leak in.
      assign src_valid = IN_VALID;
      assign src_data  = IN_VALID ? D  : '0;
      assign src_op    = IN_VALID ? OP : 2'b00;
      assign src_s     = IN_VALID ? S  : '0;
    end else begin : g_src_prev
      assign src_valid = stage_valid[k-1];
      assign src_data  = stage_data[k-1];
      assign src_op    = g_stage[k-1].g_carry.op_q;
      assign src_s     = g_stage[k-1].g_carry.s_q;
    end

    // Next stage contents: hold on stall, otherwise shift the upstream entry.
    always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (!stall) begin
        valid_d = src_valid;
        data_d  = stage_shift(src_data, src_op, src_s[0], AMT);
      end
    end

    // Stage data/valid register.
    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else begin
        valid_q <= valid_d;
        data_q  <= data_d;
      end
    end

    assign stage_valid[k] = valid_q;
    assign stage_data[k]  = data_q;

    // The last stage needs no control beyond its own input, so only the
    // earlier stages register OP and the still-unused shift bits.
    if (k < SW - 1) begin : g_carry
      logic [1:0]      op_d;
      logic [1:0]      op_q;
      logic [SW-k-2:0] s_d;
      logic [SW-k-2:0] s_q;

      // Control bits follow the data and freeze with it.
      always_comb begin
        op_d = op_q;
        s_d  = s_q;
        if (!stall) begin
          op_d = src_op;
          s_d  = src_s[SW-k-1:1];
        end
      end

      // Control register for the downstream stages.
      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          op_q <= 2'b00;
          s_q  <= '0;
        end else begin
          op_q <= op_d;
          s_q  <= s_d;
        end
      end
    end
  end

  // Zero flag is computed from the final stage's next data so it lands in
  // the same cycle as Y and holds with it during a stall.
  always_comb begin
    zero_d = (g_stage[SW-1].data_d == '0);
  end

  // Zero flag register alongside the output data.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      zero_q <= 1'b0;
    end else begin
      zero_q <= zero_d;
    end
  end

endmodule

`default_nettype wire
